ball_motion: RTL and testbench
==============================

# ball_motion

Sequential ball-motion controller for the paddle game; it owns the ball position and consumes the collision flags computed from that position. Each game tick it either counts down a serve delay, advances the ball one pixel per axis, reflects off walls, ceiling and paddle, or registers a miss on floor contact and re-serves. Its `ballX`/`ballY` outputs feed the collision detector and the renderer, and its `ballTouchingPaddle`/`ballTouchingFloor` inputs come back from the collision detector.

## Interface

- `BIT_WIDTH`, 10: coordinate width.
- `BALL_RADIUS`, 4: ball radius in pixels.
- `CEILING_Y`, 460: ceiling line; Y grows upward and the floor is at low Y.
- `LEFT_X`, 8: left wall X.
- `RIGHT_X`, 632: right wall X.
- `START_X`, 320: serve X position.
- `START_Y`, 240: serve Y position.
- `STEP_TICKS`, 2: ticks per one-pixel step; must be ≥1.
- `SERVE_TICKS`, 3: ticks held at the serve point before motion starts; must be ≥1.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `tick` input 1: one-cycle game-time strobe; nothing advances while it is low.
- `ballTouchingPaddle` input 1: paddle contact for the current `ballX`/`ballY`.
- `ballTouchingFloor` input 1: floor contact for the current `ballX`/`ballY`.
- `ballX` output BIT_WIDTH: registered ball X.
- `ballY` output BIT_WIDTH: registered ball Y.
- `ballDirX` output 1: 1 = +X, 0 = −X.
- `ballDirY` output 1: 1 = +Y (up), 0 = −Y (down).
- `ballActive` output 1: high in state MOVE.
- `missPulse` output 1: one-cycle pulse on a floor miss.

## Operation

- States: SERVE, MOVE, MISS. Internal state also includes `serveCnt`, `stepCnt` and `serveDir`.
- Reset values:
  - state SERVE; `ballX`=START_X, `ballY`=START_Y.
  - `ballDirX`=1, `ballDirY`=1, `serveDir`=1.
  - `serveCnt`=0, `stepCnt`=0.
  - `missPulse`=0, `ballActive`=0.
- SERVE:
  - Position is held.
  - On `tick`, `serveCnt`++.
  - On a `tick` with `serveCnt`==SERVE_TICKS−1: clear `serveCnt` and `stepCnt`, go to MOVE.
- MOVE:
  - On `tick` with `stepCnt`≠STEP_TICKS−1: `stepCnt`++.
  - On `tick` with `stepCnt`==STEP_TICKS−1: `stepCnt`←0 and perform a step.
- Step evaluation uses the flags and position sampled in the same cycle, before the move:
  - `ballTouchingFloor` has top priority: go to MISS, position unchanged.
  - X flip condition: `ballTouchingPaddle` OR (`ballX`≤LEFT_X and dirX=0) OR (`ballX`≥RIGHT_X and dirX=1). Several true conditions still give a single flip.
  - Y flip condition: `ballY`+BALL_RADIUS≥CEILING_Y and dirY=1.
  - The new direction is registered, and position moves ±1 per axis using the new direction in the same cycle.
- MISS (exactly one cycle):
  - `missPulse`=1.
  - On exit: `ballX`/`ballY` ← START_X/START_Y; `ballDirX`←~`serveDir`; `serveDir` toggles; `ballDirY`←1; counters clear; go to SERVE.
  - `tick` is ignored in MISS.
- Arithmetic is BIT_WIDTH wide and unsigned, computed with BIT_WIDTH+1 bits internally for the ceiling compare. Wall flips keep the ball within [LEFT_X, RIGHT_X], so no wrap-around occurs.

## Timing

- All outputs are registered; a change appears the cycle after the qualifying `tick` edge.
- Collision inputs are combinational from `ballX`/`ballY`, so zero extra latency: the flags seen at a step describe the current position.
- Inputs are sampled only on step cycles; contact between steps is ignored.
- `missPulse` is high for exactly the one cycle spent in MISS. The ball is back at the start position the following cycle.
- `ballActive` = (state==MOVE).
- `reset` has priority over everything, including mid-MOVE and a MISS cycle, and restores all reset values on the next edge.

## Test plan

- Reset with `tick`=0 for 5 cycles → (320,240), `ballDirX`=1, `ballDirY`=1, `ballActive`=0, `missPulse`=0; still unchanged after 5 more cycles with `tick`=0.
- Serve and first step, `tick` every cycle → `ballActive` rises after the 3rd tick; after 2 more ticks the ball is at (321,241).
- Ceiling: free-run until `ballY`=456 (456+4=460) → next step gives `ballDirY`=0, `ballY`=455.
- Paddle: `ballTouchingPaddle`=1 on a step cycle with dirX=1 at X=400 → `ballDirX`=0, `ballX`=399. Paddle=1 on a non-step tick → no change.
- Floor miss: `ballTouchingFloor`=1 and `ballTouchingPaddle`=1 on the same step → exactly one `missPulse` cycle, no position change during it; next cycle (320,240), `ballDirX`=0, SERVE. A second miss serves with `ballDirX`=1.
- Assert `reset` mid-MOVE at (350,270) → all reset values the next cycle; serve timing then restarts from zero.

Source files
------------

// File: rtl/ball_motion_if.sv
// Ball controller bus: game tick and collision flags in, ball state out.
interface ball_motion_if #(
   parameter int BIT_WIDTH = 10
);
   logic                 tick;
   logic                 ballTouchingPaddle;
   logic                 ballTouchingFloor;
   logic [BIT_WIDTH-1:0] ballX;
   logic [BIT_WIDTH-1:0] ballY;
   logic                 ballDirX;
   logic                 ballDirY;
   logic                 ballActive;
   logic                 missPulse;

   modport master (
      input  tick, ballTouchingPaddle, ballTouchingFloor,
      output ballX, ballY, ballDirX, ballDirY, ballActive, missPulse
   );

   modport slave (
      output tick, ballTouchingPaddle, ballTouchingFloor,
      input  ballX, ballY, ballDirX, ballDirY, ballActive, missPulse
   );
endinterface

// File: rtl/ball_motion.sv
// Ball position/direction controller: serve delay, one-pixel steps, wall/ceiling/paddle
// reflection and floor-miss re-serve, all paced by the game tick.
module ball_motion #(
   parameter int BIT_WIDTH   = 10,
   parameter int BALL_RADIUS = 4,
   parameter int CEILING_Y   = 460,
   parameter int LEFT_X      = 8,
   parameter int RIGHT_X     = 632,
   parameter int START_X     = 320,
   parameter int START_Y     = 240,
   parameter int STEP_TICKS  = 2,
   parameter int SERVE_TICKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   ball_motion_if.master    bus
);

   localparam int SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam int TCW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

   localparam logic [SCW-1:0]       SERVE_LAST = SCW'(SERVE_TICKS - 1);
   localparam logic [TCW-1:0]       STEP_LAST  = TCW'(STEP_TICKS - 1);
   localparam logic [BIT_WIDTH-1:0] X_START    = BIT_WIDTH'(START_X);
   localparam logic [BIT_WIDTH-1:0] Y_START    = BIT_WIDTH'(START_Y);
   localparam logic [BIT_WIDTH-1:0] X_LEFT     = BIT_WIDTH'(LEFT_X);
   localparam logic [BIT_WIDTH-1:0] X_RIGHT    = BIT_WIDTH'(RIGHT_X);
   localparam logic [BIT_WIDTH:0]   RADIUS_EXT = (BIT_WIDTH + 1)'(BALL_RADIUS);
   localparam logic [BIT_WIDTH:0]   CEIL_EXT   = (BIT_WIDTH + 1)'(CEILING_Y);

   typedef enum logic [1:0] {SERVE, MOVE, MISS} state_t;

   state_t               state, state_next;
   logic [SCW-1:0]       serve_cnt;
   logic [TCW-1:0]       step_cnt;
   logic                 serve_dir;
   logic [BIT_WIDTH-1:0] ball_x, ball_y;
   logic                 dir_x, dir_y;
   logic                 ball_active, miss_pulse;

   logic                 serve_done, step_now;
   logic                 flip_x, flip_y, dir_x_new, dir_y_new;
   logic [BIT_WIDTH:0]   ball_top;

   assign serve_done = (state == SERVE) && bus.tick && (serve_cnt == SERVE_LAST);
   assign step_now   = (state == MOVE) && bus.tick && (step_cnt == STEP_LAST);

   // Flags and position are sampled before the move; any X condition yields one flip.
   assign flip_x    = bus.ballTouchingPaddle
                    | ((ball_x <= X_LEFT)  && !dir_x)
                    | ((ball_x >= X_RIGHT) &&  dir_x);
   assign ball_top  = {1'b0, ball_y} + RADIUS_EXT;
   assign flip_y    = (ball_top >= CEIL_EXT) && dir_y;
   assign dir_x_new = dir_x ^ flip_x;
   assign dir_y_new = dir_y ^ flip_y;

   always_ff @(posedge clk) begin
      if (reset) state <= SERVE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         SERVE:   if (serve_done) state_next = MOVE;
         MOVE:    if (step_now && bus.ballTouchingFloor) state_next = MISS;
         MISS:    state_next = SERVE;
         default: state_next = SERVE;
      endcase
   end

   always_comb begin
      ball_active = (state == MOVE);
      miss_pulse  = (state == MISS);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ball_x    <= X_START;
         ball_y    <= Y_START;
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         serve_dir <= 1'b1;
         serve_cnt <= '0;
         step_cnt  <= '0;
      end else begin
         unique case (state)
            SERVE: begin
               if (bus.tick) begin
                  if (serve_cnt == SERVE_LAST) begin
                     serve_cnt <= '0;
                     step_cnt  <= '0;
                  end else begin
                     serve_cnt <= serve_cnt + 1'b1;
                  end
               end
            end
            MOVE: begin
               if (bus.tick) begin
                  if (step_cnt != STEP_LAST) begin
                     step_cnt <= step_cnt + 1'b1;
                  end else begin
                     step_cnt <= '0;
                     if (!bus.ballTouchingFloor) begin
                        dir_x  <= dir_x_new;
                        dir_y  <= dir_y_new;
                        ball_x <= dir_x_new ? ball_x + 1'b1 : ball_x - 1'b1;
                        ball_y <= dir_y_new ? ball_y + 1'b1 : ball_y - 1'b1;
                     end
                  end
               end
            end
            MISS: begin
               ball_x    <= X_START;
               ball_y    <= Y_START;
               dir_x     <= ~serve_dir;
               serve_dir <= ~serve_dir;
               dir_y     <= 1'b1;
               serve_cnt <= '0;
               step_cnt  <= '0;
            end
            default: begin
               serve_cnt <= '0;
               step_cnt  <= '0;
            end
         endcase
      end
   end

   assign bus.ballX      = ball_x;
   assign bus.ballY      = ball_y;
   assign bus.ballDirX   = dir_x;
   assign bus.ballDirY   = dir_y;
   assign bus.ballActive = ball_active;
   assign bus.missPulse  = miss_pulse;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed stimulus, a behavioural reference checked every cycle,
// and hand-computed expectations at the key points of each scenario.
module tb_ball_motion;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   ball_motion_if #(.BIT_WIDTH(10)) bus ();

   ball_motion dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference: plain integers following the game rules.
   int m_x, m_y, m_phase, m_ticks;    // phase 0 serve, 1 moving, 2 missed
   bit m_dx, m_dy, m_sdir, m_valid = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_x = 320; m_y = 240; m_dx = 1; m_dy = 1; m_sdir = 1;
         m_phase = 0; m_ticks = 0; m_valid = 1;
      end else if (m_valid) begin
         if (m_phase == 2) begin
            m_x = 320; m_y = 240; m_dx = !m_sdir; m_sdir = !m_sdir; m_dy = 1;
            m_phase = 0; m_ticks = 0;
         end else if (bus.tick) begin
            m_ticks++;
            if (m_phase == 0 && m_ticks == 3) begin
               m_phase = 1; m_ticks = 0;
            end else if (m_phase == 1 && m_ticks == 2) begin
               m_ticks = 0;
               if (bus.ballTouchingFloor) m_phase = 2;
               else begin
                  if (bus.ballTouchingPaddle || (m_x <= 8 && !m_dx) || (m_x >= 632 && m_dx))
                     m_dx = !m_dx;
                  if (m_y + 4 >= 460 && m_dy) m_dy = 0;
                  m_x = m_dx ? m_x + 1 : m_x - 1;
                  m_y = m_dy ? m_y + 1 : m_y - 1;
               end
            end
         end
      end
   end

   function automatic logic [31:0] pack(input logic [9:0] x, input logic [9:0] y,
                                        input logic dx, input logic dy,
                                        input logic act, input logic miss);
      return {8'h00, x, y, dx, dy, act, miss};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (x,y,dx,dy,active,miss packed)", name, act, exp);
   endtask

   function automatic logic [31:0] dut_pack();
      return pack(bus.ballX, bus.ballY, bus.ballDirX, bus.ballDirY, bus.ballActive, bus.missPulse);
   endfunction

   always @(negedge clk) begin
      if (m_valid)
         check("model", dut_pack(),
               pack(10'(m_x), 10'(m_y), m_dx, m_dy, m_phase == 1, m_phase == 2));
   end

   task automatic cyc(input logic t, input logic p, input logic f);
      bus.tick = t; bus.ballTouchingPaddle = p; bus.ballTouchingFloor = f;
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_x(input int target, input int limit);
      int n = 0;
      while (bus.ballX != 10'(target) && n < limit) begin
         cyc(1, 0, 0);
         n++;
      end
      if (bus.ballX != 10'(target)) check("reach_x_timeout", 32'(bus.ballX), 32'(target));
   endtask

   task automatic run_until_y(input int target, input int limit);
      int n = 0;
      while (bus.ballY != 10'(target) && n < limit) begin
         cyc(1, 0, 0);
         n++;
      end
      if (bus.ballY != 10'(target)) check("reach_y_timeout", 32'(bus.ballY), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1;
      bus.tick = 0; bus.ballTouchingPaddle = 0; bus.ballTouchingFloor = 0;
      repeat (5) cyc(0, 0, 0);
      check("reset_state", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      reset = 0;
      repeat (5) cyc(0, 0, 0);
      check("idle_no_tick", dut_pack(), pack(320, 240, 1, 1, 0, 0));

      // Serve then first step
      cyc(1, 0, 0); cyc(1, 0, 0);
      check("serve_2_ticks", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      cyc(1, 0, 0);
      check("serve_3_ticks", dut_pack(), pack(320, 240, 1, 1, 1, 0));
      cyc(1, 0, 0);
      check("non_step_tick", dut_pack(), pack(320, 240, 1, 1, 1, 0));
      cyc(1, 0, 0);
      check("first_step", dut_pack(), pack(321, 241, 1, 1, 1, 0));

      // Ceiling bounce
      run_until_y(456, 1000);
      check("at_456", dut_pack(), pack(536, 456, 1, 1, 1, 0));
      cyc(1, 0, 0); cyc(1, 0, 0);
      check("ceiling_flip", dut_pack(), pack(537, 455, 1, 0, 1, 0));

      // Reset from MOVE, then reset again at (350,270)
      reset = 1; cyc(1, 0, 0); reset = 0;
      check("reset_after_ceiling", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
      check("reserve_active", dut_pack(), pack(320, 240, 1, 1, 1, 0));
      run_until_x(350, 200);
      check("at_350", dut_pack(), pack(350, 270, 1, 1, 1, 0));
      reset = 1; cyc(1, 0, 0); reset = 0;
      check("reset_mid_move", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      cyc(1, 0, 0); cyc(1, 0, 0);
      check("restart_2_ticks", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      cyc(1, 0, 0);
      check("restart_3_ticks", dut_pack(), pack(320, 240, 1, 1, 1, 0));

      // Paddle: ignored between steps, reflects on a step
      run_until_x(400, 400);
      cyc(1, 1, 0);
      check("paddle_non_step", dut_pack(), pack(400, 320, 1, 1, 1, 0));
      cyc(1, 1, 0);
      check("paddle_step", dut_pack(), pack(399, 321, 0, 1, 1, 0));

      // Floor miss with paddle also set
      cyc(1, 0, 0);
      cyc(1, 1, 1);
      check("miss_cycle", dut_pack(), pack(399, 321, 0, 1, 0, 1));
      cyc(1, 0, 0);
      check("after_miss", dut_pack(), pack(320, 240, 0, 1, 0, 0));
      cyc(1, 0, 0); cyc(1, 0, 0);
      check("serve2_2_ticks", dut_pack(), pack(320, 240, 0, 1, 0, 0));
      cyc(1, 0, 0);
      check("serve2_active", dut_pack(), pack(320, 240, 0, 1, 1, 0));
      cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("second_miss", dut_pack(), pack(320, 240, 0, 1, 0, 1));
      cyc(0, 0, 0);
      check("second_serve_dir", dut_pack(), pack(320, 240, 1, 1, 0, 0));
      cyc(0, 0, 0);
      check("miss_one_cycle", dut_pack(), pack(320, 240, 1, 1, 0, 0));

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
